// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants: default datapath width, the NOP encoding and a pointer-width helper.
// Latency: none (package only).
// Backpressure: none (package only).
package arm_pkg;

    // Default PC / instruction width of the pipeline datapath.
    localparam int N_DEFAULT = 32;

    // Instruction presented to decode when no fetched word is available.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Pointer width for a queue of the given depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/queue_storage.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port right after the writing edge; read is combinational.
// Backpressure: none; the owner decides when a write is allowed.
module queue_storage #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    // Contents are deliberately left unreset; validity is tracked by the owner's count.
    logic [W-1:0] mem [DEPTH];

    // Capture the write data into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed entry.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode prefetch FIFO, first-word-fall-through, discarded on a taken branch.
// Latency: a pair written at edge t is the visible head right after t; consumable at t+1.
// Backpressure: freezeOut while full (decoded from registered count only); writes while full are dropped.
module fetch_queue
    import arm_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrValid,
    input  logic [N-1:0]               PCIn,
    input  logic [N-1:0]               instructionIn,
    output logic                       freezeOut,
    input  logic                       flush,
    input  logic                       rdEn,
    output logic                       validOut,
    output logic [N-1:0]               PCOut,
    output logic [N-1:0]               instructionOut,
    output logic [ptr_width(DEPTH):0]  count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_nxt;
    logic           wr_accept;
    logic           rd_accept;
    logic [2*N-1:0] head_dat;

    // Status flags come only from the registered count so rdEn never reaches freezeOut.
    assign freezeOut = (count_q == FULL_CNT);
    assign validOut  = (count_q != '0);
    assign count     = count_q;

    // A flush cancels both the incoming pair and any consume in the same cycle.
    assign wr_accept = wrValid && !freezeOut && !flush;
    assign rd_accept = rdEn && validOut && !flush;

    // Occupancy update: a simultaneous read and write leave the count unchanged.
    always_comb begin
        count_nxt = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Pointer and count registers; flush behaves like a synchronous reset of the queue state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_nxt;
        end
    end

    queue_storage #(
        .W     (2 * N),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata ({PCIn, instructionIn}),
        .raddr (rd_ptr),
        .rdata (head_dat)
    );

    // Present the head entry, or a zero PC and a NOP when nothing is buffered.
    always_comb begin
        PCOut          = '0;
        instructionOut = N'(NOP_INSTR);
        if (validOut) begin
            PCOut          = head_dat[2*N-1:N];
            instructionOut = head_dat[N-1:0];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected pairs, a monitor pops on every consume.
// Latency: checks head/state one cycle after each driven edge.
// Backpressure: the bench decides per vector whether a write is expected to be accepted.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        wrValid;
    logic [31:0] PCIn;
    logic [31:0] instructionIn;
    logic        freezeOut;
    logic        flush;
    logic        rdEn;
    logic        validOut;
    logic [31:0] PCOut;
    logic [31:0] instructionOut;
    logic [2:0]  count;

    int vec_cnt = 0;
    int mis_cnt = 0;
    logic [63:0] exp_q[$];

    fetch_queue #(.N(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wrValid        (wrValid),
        .PCIn           (PCIn),
        .instructionIn  (instructionIn),
        .freezeOut      (freezeOut),
        .flush          (flush),
        .rdEn           (rdEn),
        .validOut       (validOut),
        .PCOut          (PCOut),
        .instructionOut (instructionOut),
        .count          (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, record the expected effect, advance past the edge.
    task automatic step(input logic wv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rd, input logic fl, input logic acc);
        wrValid       = wv;
        PCIn          = pc;
        instructionIn = ins;
        rdEn          = rd;
        flush         = fl;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back({pc, ins});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd1();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: whenever decode consumes the head, compare it with the oldest expected pair.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst && rdEn && validOut && !flush) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    mis_cnt++;
                    $display("FAIL pop_unexpected: got PC %h, expected no entry", PCOut);
                end else begin
                    e = exp_q.pop_front();
                    check("head_pc", PCOut, e[63:32]);
                    check("head_instr", instructionOut, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, checked between edges.
        rst           = 1'b0;
        wrValid       = 1'($urandom);
        PCIn          = $urandom;
        instructionIn = $urandom;
        rdEn          = 1'($urandom);
        flush         = 1'($urandom);
        #2;
        check("rst_valid", {31'b0, validOut}, 32'd0);
        check("rst_freeze", {31'b0, freezeOut}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_pc", PCOut, 32'h0);
        check("rst_instr", instructionOut, 32'h0);
        wrValid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_count", {29'b0, count}, 32'd0);
        wrValid = 1'b0; rdEn = 1'b0; flush = 1'b0; PCIn = '0; instructionIn = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full; head visible right after the first write.
        step(1'b1, 32'd4, 32'hE0800001, 1'b0, 1'b0, 1'b1);
        check("first_count", {29'b0, count}, 32'd1);
        check("first_valid", {31'b0, validOut}, 32'd1);
        check("first_pc", PCOut, 32'd4);
        step(1'b1, 32'd8,  32'hE0800002, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd12, 32'hE0800003, 1'b0, 1'b0, 1'b1);
        check("fill3_freeze", {31'b0, freezeOut}, 32'd0);
        step(1'b1, 32'd16, 32'hE0800004, 1'b0, 1'b0, 1'b1);
        check("full_count", {29'b0, count}, 32'd4);
        check("full_freeze", {31'b0, freezeOut}, 32'd1);
        step(1'b1, 32'd20, 32'hE0800005, 1'b0, 1'b0, 1'b0);
        check("drop_count", {29'b0, count}, 32'd4);
        check("drop_head", PCOut, 32'd4);

        // Drain in order.
        rd1();
        check("unfreeze", {31'b0, freezeOut}, 32'd0);
        check("drain1_count", {29'b0, count}, 32'd3);
        rd1(); rd1(); rd1();
        check("empty_valid", {31'b0, validOut}, 32'd0);
        check("empty_count", {29'b0, count}, 32'd0);
        check("empty_pc", PCOut, 32'h0);
        check("empty_instr", instructionOut, 32'h0);
        rd1();
        check("rd_empty_count", {29'b0, count}, 32'd0);
        idle();

        // Simultaneous read/write at count 2 across pointer wrap.
        step(1'b1, 32'h200, 32'hE1A00000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h204, 32'hE1A00001, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'h208 + 32'(4 * k), 32'hE2800000 + 32'(k), 1'b1, 1'b0, 1'b1);
            check("rw_count", {29'b0, count}, 32'd2);
        end
        rd1(); rd1();
        check("rw_drained", {29'b0, count}, 32'd0);

        // Flush at count 3 with write and read offered.
        step(1'b1, 32'h300, 32'hE3A00001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h304, 32'hE3A00002, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h308, 32'hE3A00003, 1'b0, 1'b0, 1'b1);
        check("pre_flush_count", {29'b0, count}, 32'd3);
        step(1'b1, 32'h30C, 32'hE3A00004, 1'b1, 1'b1, 1'b0);
        check("flush_count", {29'b0, count}, 32'd0);
        check("flush_valid", {31'b0, validOut}, 32'd0);
        check("flush_freeze", {31'b0, freezeOut}, 32'd0);
        step(1'b1, 32'h104, 32'hEA000010, 1'b0, 1'b0, 1'b1);
        check("branch_head_pc", PCOut, 32'h104);
        check("branch_count", {29'b0, count}, 32'd1);
        rd1();

        // Full with read and write together: read taken, write dropped.
        step(1'b1, 32'h400, 32'hE5900000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h404, 32'hE5900001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h408, 32'hE5900002, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h40C, 32'hE5900003, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h410, 32'hE5900004, 1'b1, 1'b0, 1'b0);
        check("fullrw_count", {29'b0, count}, 32'd3);
        check("fullrw_freeze", {31'b0, freezeOut}, 32'd0);
        rd1(); rd1(); rd1();

        // Asynchronous reset between edges at count 2.
        step(1'b1, 32'h500, 32'hE0000001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h504, 32'hE0000002, 1'b0, 1'b0, 1'b1);
        wrValid = 1'b0;
        check("pre_arst_count", {29'b0, count}, 32'd2);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", {31'b0, validOut}, 32'd0);
        check("arst_count", {29'b0, count}, 32'd0);
        check("arst_pc", PCOut, 32'h0);
        check("arst_instr", instructionOut, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h600, 32'hE0000060, 1'b0, 1'b0, 1'b1);
        check("post_arst_pc", PCOut, 32'h600);
        check("post_arst_count", {29'b0, count}, 32'd1);
        rd1();
        idle();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue sitting between the fetch stage and the decode stage of the ARM pipeline. It accepts (PC+4, instruction) pairs produced each cycle by fetch, buffers up to DEPTH of them, and presents the oldest pair to decode in first-word-fall-through order. It is the consuming end of the fetch interface. It back-pressures fetch through `freezeOut` and discards all buffered entries when a branch is taken.

## Interface
- `N`, 32, datapath width of PC and instruction.
- `DEPTH`, 4, queue entries; must be a power of two and at least 2.

- `clk`  input  1  pipeline clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `wrValid`  input  1  fetch presents a valid pair this cycle.
- `PCIn`  input  N  PC+4 from fetch.
- `instructionIn`  input  N  fetched instruction.
- `freezeOut`  output  1  queue full; drives fetch freeze.
- `flush`  input  1  branch taken; discard every buffered entry.
- `rdEn`  input  1  decode consumes the head entry this cycle.
- `validOut`  output  1  head entry valid (queue not empty).
- `PCOut`  output  N  head PC+4; 0 when empty.
- `instructionOut`  output  N  head instruction; NOP constant (32'h0) when empty.
- `count`  output  log2(DEPTH)+1  number of buffered entries.

## Operation
- State: storage array of DEPTH × 2N bits, write pointer, read pointer (each log2(DEPTH) bits, natural wrap), and a `count` register.
- Write accepted iff `wrValid && !freezeOut && !flush`: the pair is stored at the write pointer, which then increments modulo DEPTH.
- Read accepted iff `rdEn && validOut && !flush`: the read pointer increments modulo DEPTH. `rdEn` while empty is ignored, with no pointer or count change.
- `count` next value: +1 on write only, −1 on read only, unchanged on simultaneous accepted read and write.
- `freezeOut = (count == DEPTH)` and `validOut = (count != 0)`, both decoded from registered `count` only, with no combinational path from `rdEn`. A write offered while full is dropped, even if a read occurs the same cycle. Fetch holds its PC because it is frozen.
- Flush dominates: when `flush` is high, both pointers go to 0 and `count` goes to 0, regardless of `wrValid`/`rdEn`. The pair presented by fetch that cycle is discarded. Storage contents are not cleared.
- Outputs are combinational reads of the head entry gated by `validOut`. When empty, `PCOut` is 0 and `instructionOut` is the NOP constant.

## Timing
- Reset (`rst` low, asynchronous): pointers 0, `count` 0, `validOut` 0, `freezeOut` 0, `PCOut` 0, `instructionOut` NOP. The effect is immediate, without waiting for a clock edge.
- Reset asserted mid-operation discards all entries exactly as a flush does. The first write is accepted on the first rising edge after `rst` deasserts.
- Latency: a pair written at edge t appears on the outputs after edge t with `validOut` high, so decode can consume it at edge t+1. Minimum write-to-consume is 1 cycle.
- `freezeOut` rises in the cycle after the DEPTH-th write. It falls in the cycle after the first read from full.
- Flush takes effect at the edge where it is sampled. In the following cycle `validOut` is 0 and `freezeOut` is 0. A write on the cycle after flush is accepted normally, so the branch-target fetch is the next head entry.
- Pointer wrap: after DEPTH writes and reads, pointers return to 0 with no bubble.

## Structure
- Shared package `arm_pkg`: `NOP_INSTR` = 32'h0, default width `N` = 32, and a helper for the pointer width (clog2).
- One natural sub-module is `queue_storage`. It is a DEPTH × 2N register file with a synchronous write port, an asynchronous read port, and no reset on its contents.
- Pointer, count, and flush logic live in `fetch_queue`.

## Test plan
- **Reset:** `rst`=0 with random inputs → `validOut`=0, `freezeOut`=0, `count`=0, `PCOut`=0, `instructionOut`=32'h0.
- **Fill/drain:** write 4 pairs (PC 4, 8, 12, 16; instr E0800001..E0800004) with `rdEn`=0 → `count`=4, `freezeOut`=1; a 5th write is dropped. Then `rdEn`=1 → outputs the four pairs in order, then `validOut`=0.
- **Simultaneous read/write at count=2** → `count` stays 2, FIFO order is preserved across 10 cycles of pointer wrap.
- **Flush with `wrValid`=1 and `rdEn`=1 at count=3** → next cycle `count`=0, `validOut`=0. The next write (PC 0x104) becomes head with `PCOut`=0x104.
- **Full plus read plus write in the same cycle** → the read is accepted and the write is dropped; `count` goes 4→3 and `freezeOut`=0 next cycle.
- **Async reset mid-stream at count=2, between clock edges** → outputs clear immediately. After release, the first write appears at the head one cycle later.
